// File: rtl/seg7_bus_receiver_pkg.sv
// Shared types and tables for the 7-segment bus receiver.
// The segment table is active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  localparam seg7_t SEG7_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [7:0] EN_IDLE = 8'hFF;

  // True when exactly one enable bit is low.
  function automatic logic en_one_hot_low(input logic [7:0] en);
    logic [7:0] act;
    act = ~en;
    return (act != 8'h00) && ((act & (act - 8'h01)) == 8'h00);
  endfunction

  // Position of the lowest low enable bit; only meaningful when one-hot-low.
  function automatic logic [2:0] en_index(input logic [7:0] en);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!en[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_bus_receiver_if.sv
// Multiplexed display bus: segments, digit enables and decimal point, all active-low.
interface seg7_bus_receiver_if;
  import seg7_pkg::*;

  seg7_t      seven_seg;
  logic [7:0] en;
  logic       dp;

  modport master (output seven_seg, output en, output dp);
  modport slave  (input  seven_seg, input  en, input  dp);
endinterface

// File: rtl/seg7_bus_receiver_seg7_to_hex.sv
// Segment-pattern to hex decoder; inverse of the hex-to-segment display table.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  seg7_t      seg,
  output logic [3:0] hex,
  output logic       legal
);

  always_comb begin
    hex   = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_CODES[i]) begin
        hex   = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_bus_receiver.sv
// Receive side of the multiplexed 7-segment bus: synchronize, qualify each
// digit slot as stable, decode it and keep an 8-digit image of the display.
module seg7_bus_receiver
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  seg7_bus_receiver_if.slave  bus,
  output logic [31:0]         digits,
  output logic [7:0]          dp_img,
  output logic [7:0]          digit_valid,
  output logic                new_digit,
  output logic [2:0]          new_idx,
  output logic                frame_done,
  output logic                pat_err,
  output logic                en_err
);

  localparam int WORD_W = 16;
  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Synchronizer: idle bus is all ones so it resets that way.
  logic [WORD_W-1:0] sync_d [SYNC_STAGES];
  logic [WORD_W-1:0] sync_q [SYNC_STAGES];
  logic [WORD_W-1:0] prev_d, prev_q;
  logic [WORD_W-1:0] s_word;
  logic [7:0]        s_en;
  seg7_t             s_seg;
  logic              s_dp;
  logic              changed;

  always_comb begin
    sync_d[0] = {bus.en, bus.seven_seg, bus.dp};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      prev_q <= '1;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q <= prev_d;
    end
  end

  assign s_word  = sync_q[SYNC_STAGES-1];
  assign prev_d  = s_word;
  assign s_en    = s_word[15:8];
  assign s_seg   = s_word[7:1];
  assign s_dp    = s_word[0];
  assign changed = (s_word != prev_q);

  logic [3:0] dec_hex;
  logic       dec_legal;

  seg7_to_hex u_dec (
    .seg   (s_seg),
    .hex   (dec_hex),
    .legal (dec_legal)
  );

  // Slot tracking FSM.
  rx_state_t        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_en != EN_IDLE) state_d = TRACK;
      end
      TRACK: begin
        if (changed) begin
          cnt_d = '0;
          if (s_en == EN_IDLE) state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (changed) begin
          cnt_d   = '0;
          state_d = (s_en == EN_IDLE) ? IDLE : TRACK;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Evaluation and the registered result image.
  logic        eval;
  logic        en_ok;
  logic [2:0]  idx;
  logic [31:0] digits_d, digits_q;
  logic [7:0]  dp_img_d, dp_img_q;
  logic [7:0]  valid_d, valid_q;
  logic [7:0]  mask_d, mask_q;
  logic [7:0]  mask_next;
  logic        new_digit_d, new_digit_q;
  logic [2:0]  new_idx_d, new_idx_q;
  logic        frame_done_d, frame_done_q;
  logic        pat_err_d, pat_err_q;
  logic        en_err_d, en_err_q;

  assign en_ok = en_one_hot_low(s_en);
  assign idx   = en_index(s_en);

  always_comb begin
    eval         = (state_q == TRACK) && !changed && (cnt_q == CNT_LAST);
    digits_d     = digits_q;
    dp_img_d     = dp_img_q;
    valid_d      = valid_q;
    mask_d       = mask_q;
    mask_next    = mask_q;
    new_digit_d  = 1'b0;
    new_idx_d    = new_idx_q;
    frame_done_d = 1'b0;
    pat_err_d    = 1'b0;
    en_err_d     = 1'b0;
    if (eval) begin
      if (!en_ok) begin
        en_err_d = 1'b1;
      end else if (!dec_legal) begin
        pat_err_d = 1'b1;
      end else begin
        digits_d[{idx, 2'b00} +: 4] = dec_hex;
        dp_img_d[idx]  = ~s_dp;
        valid_d[idx]   = 1'b1;
        new_digit_d    = 1'b1;
        new_idx_d      = idx;
        mask_next[idx] = 1'b1;
        // A completed frame restarts the mask in the same cycle it pulses.
        if (mask_next == 8'hFF) begin
          frame_done_d = 1'b1;
          mask_d       = 8'h00;
        end else begin
          mask_d = mask_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q     <= '0;
      dp_img_q     <= '0;
      valid_q      <= '0;
      mask_q       <= '0;
      new_digit_q  <= 1'b0;
      new_idx_q    <= '0;
      frame_done_q <= 1'b0;
      pat_err_q    <= 1'b0;
      en_err_q     <= 1'b0;
    end else begin
      digits_q     <= digits_d;
      dp_img_q     <= dp_img_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      new_digit_q  <= new_digit_d;
      new_idx_q    <= new_idx_d;
      frame_done_q <= frame_done_d;
      pat_err_q    <= pat_err_d;
      en_err_q     <= en_err_d;
    end
  end

  assign digits      = digits_q;
  assign dp_img      = dp_img_q;
  assign digit_valid = valid_q;
  assign new_digit   = new_digit_q;
  assign new_idx     = new_idx_q;
  assign frame_done  = frame_done_q;
  assign pat_err     = pat_err_q;
  assign en_err      = en_err_q;

endmodule

// File: tb/tb_seg7_bus_receiver.sv
// Directed bench for seg7_bus_receiver: table-driven digit captures plus
// hand-written glitch, error and reset sequences.
module tb_seg7_bus_receiver;
  import seg7_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] digits;
  logic [7:0]  dp_img;
  logic [7:0]  digit_valid;
  logic        new_digit;
  logic [2:0]  new_idx;
  logic        frame_done;
  logic        pat_err;
  logic        en_err;

  seg7_bus_receiver_if bus ();

  seg7_bus_receiver #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .digits      (digits),
    .dp_img      (dp_img),
    .digit_valid (digit_valid),
    .new_digit   (new_digit),
    .new_idx     (new_idx),
    .frame_done  (frame_done),
    .pat_err     (pat_err),
    .en_err      (en_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int n_new   = 0;
  int n_frame = 0;
  int n_pat   = 0;
  int n_en    = 0;
  int n_viol  = 0;
  logic [2:0] last_idx = 3'd0;

  always @(negedge clk) begin
    if (!rst) begin
      if (new_digit) begin
        n_new++;
        last_idx = new_idx;
      end
      if (frame_done) n_frame++;
      if (pat_err)    n_pat++;
      if (en_err)     n_en++;
      if ((int'(new_digit) + int'(pat_err) + int'(en_err)) > 1) n_viol++;
      if (frame_done && !new_digit) n_viol++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] en, input logic [6:0] seg, input logic dp);
    bus.en        = en;
    bus.seven_seg = seg;
    bus.dp        = dp;
  endtask

  typedef struct {
    logic [7:0] en;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic [3:0] hex;
  } vec_t;

  vec_t tbl [8];

  int base_new, base_pat, base_en, base_frame;

  initial begin
    tbl[0] = '{8'hFE, 7'h40, 1'b1, 3'd0, 4'h0};
    tbl[1] = '{8'hFD, 7'h79, 1'b0, 3'd1, 4'h1};
    tbl[2] = '{8'hFB, 7'h24, 1'b1, 3'd2, 4'h2};
    tbl[3] = '{8'hF7, 7'h30, 1'b0, 3'd3, 4'h3};
    tbl[4] = '{8'hEF, 7'h19, 1'b1, 3'd4, 4'h4};
    tbl[5] = '{8'hDF, 7'h12, 1'b0, 3'd5, 4'h5};
    tbl[6] = '{8'hBF, 7'h02, 1'b1, 3'd6, 4'h6};
    tbl[7] = '{8'h7F, 7'h78, 1'b0, 3'd7, 4'h7};

    rst = 1'b1;
    drive(8'hFF, 7'h7F, 1'b1);
    tick(3);
    chk("reset_digits", digits, 32'h0);
    chk("reset_dp_img", {24'h0, dp_img}, 32'h0);
    chk("reset_valid", {24'h0, digit_valid}, 32'h0);
    chk("reset_pulses", {28'h0, new_digit, frame_done, pat_err, en_err}, 32'h0);
    rst = 1'b0;
    tick(4);

    // Single digit: latency is 6 edges counted from the first sampling edge.
    base_new = n_new;
    drive(8'hF7, 7'h30, 1'b1);
    tick(6);
    chk("single_not_early", {31'h0, new_digit}, 32'h0);
    tick(1);
    chk("single_new_digit", {31'h0, new_digit}, 32'h1);
    chk("single_new_idx", {29'h0, new_idx}, 32'h3);
    chk("single_digits", digits, 32'h0000_3000);
    chk("single_valid", {24'h0, digit_valid}, 32'h08);
    chk("single_dp_img", {24'h0, dp_img}, 32'h00);
    tick(3);
    chk("single_one_pulse", n_new - base_new, 32'd1);
    drive(8'hFF, 7'h7F, 1'b1);
    tick(6);

    // Illegal (blank) pattern on digit 2.
    base_new = n_new;
    base_pat = n_pat;
    drive(8'hFB, 7'h7F, 1'b1);
    tick(8);
    chk("illegal_pat_err", n_pat - base_pat, 32'd1);
    chk("illegal_no_capture", n_new - base_new, 32'd0);
    chk("illegal_digit2", {28'h0, digits[11:8]}, 32'h0);
    chk("illegal_valid2", {31'h0, digit_valid[2]}, 32'h0);
    drive(8'hFF, 7'h7F, 1'b1);
    tick(6);

    // Two enables low at once, then back to blank.
    base_new = n_new;
    base_en  = n_en;
    drive(8'hFC, 7'h00, 1'b1);
    tick(8);
    chk("en_err_pulse", n_en - base_en, 32'd1);
    chk("en_err_no_capture", n_new - base_new, 32'd0);
    chk("en_err_digits", digits, 32'h0000_3000);
    base_pat = n_pat;
    base_en  = n_en;
    drive(8'hFF, 7'h00, 1'b1);
    tick(8);
    chk("blank_state_idle", {30'h0, dut.state_q}, {30'h0, IDLE});
    chk("blank_no_pulses", (n_new - base_new) + (n_pat - base_pat) + (n_en - base_en), 32'd0);

    // Full frame, digit i showing i, odd digits with dp lit.
    base_frame = n_frame;
    base_pat   = n_pat;
    base_en    = n_en;
    for (int i = 0; i < 8; i++) begin
      base_new = n_new;
      drive(tbl[i].en, tbl[i].seg, tbl[i].dp);
      tick(8);
      chk($sformatf("frame_capture_%0d", i), n_new - base_new, 32'd1);
      chk($sformatf("frame_idx_%0d", i), {29'h0, last_idx}, {29'h0, tbl[i].idx});
      chk($sformatf("frame_hex_%0d", i), {28'h0, digits[4*i +: 4]}, {28'h0, tbl[i].hex});
      chk($sformatf("frame_dp_%0d", i), {31'h0, dp_img[i]}, {31'h0, ~tbl[i].dp});
    end
    chk("frame_digits", digits, 32'h7654_3210);
    chk("frame_dp_img", {24'h0, dp_img}, 32'hAA);
    chk("frame_valid", {24'h0, digit_valid}, 32'hFF);
    chk("frame_done_once", n_frame - base_frame, 32'd1);
    chk("frame_no_errors", (n_pat - base_pat) + (n_en - base_en), 32'd0);
    drive(8'hFF, 7'h7F, 1'b1);
    tick(6);

    // Glitch: a 2-cycle "1" must not be captured, the following "2" must.
    base_new = n_new;
    drive(8'hFE, 7'h79, 1'b1);
    tick(2);
    drive(8'hFE, 7'h24, 1'b1);
    tick(8);
    chk("glitch_one_capture", n_new - base_new, 32'd1);
    chk("glitch_idx", {29'h0, last_idx}, 32'h0);
    chk("glitch_digit0", {28'h0, digits[3:0]}, 32'h2);
    drive(8'hFF, 7'h7F, 1'b1);
    tick(6);

    // Reset in the middle of a stability window.
    drive(8'hEF, 7'h12, 1'b1);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_digits", digits, 32'h0);
    chk("midrst_valid", {24'h0, digit_valid}, 32'h0);
    chk("midrst_pulses", {28'h0, new_digit, frame_done, pat_err, en_err}, 32'h0);
    rst = 1'b0;
    base_new = n_new;
    tick(6);
    chk("midrst_not_early", {24'h0, digit_valid}, 32'h0);
    tick(1);
    chk("midrst_new_digit", {31'h0, new_digit}, 32'h1);
    chk("midrst_digits_after", digits, 32'h0005_0000);
    chk("midrst_valid_after", {24'h0, digit_valid}, 32'h10);
    tick(4);
    chk("midrst_one_capture", n_new - base_new, 32'd1);

    chk("pulse_exclusive", n_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
